// File: rtl/ps2_key_controller.sv
// ps2_key_controller: decodes a PS/2 set-2 byte stream into key events.
// It tracks held state for W/S/Up/Down/Space and turns it into paddle motion
// requests plus a pause toggle.
//
// Optional build macro PS2_KEY_EVENT_FIFO_EN:
//   undefined -> o_evt_valid is a one-cycle pulse and the fields hold until the
//                next event. i_evt_ready is ignored and o_evt_overflow is 0.
//   defined   -> events are queued in a FIFO_DEPTH-entry FIFO (power of two, >= 2).
//                The head is presented on o_evt_*, a pop is o_evt_valid & i_evt_ready,
//                and o_evt_overflow is a sticky flag set when an event is dropped.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_data, i_data_valid        received byte and its one-cycle strobe
//   o_p1_up/down, o_p2_up/down  net paddle motion requests
//   o_pause                     pause toggle state
//   o_evt_valid/code/ext/brk    key event stream, i_evt_ready is the consumer handshake
//   o_evt_overflow              sticky event-drop flag
module ps2_key_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_p1_up,
  output logic       o_p1_down,
  output logic       o_p2_up,
  output logic       o_p2_down,
  output logic       o_pause,
  output logic       o_evt_valid,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_brk,
  input  logic       i_evt_ready,
  output logic       o_evt_overflow
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_fire_c, evt_ext_c, evt_brk_c;
  logic             w_q, s_q, up_q, dn_q, sp_q;
  logic             w_d, s_d, up_d, dn_d, sp_d, pause_d;

  // Prefix FSM state and timeout counter registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_BASE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prefix decode; a byte in the timeout cycle wins over the timeout
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    evt_fire_c = 1'b0;
    evt_ext_c  = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    evt_brk_c  = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    if (i_data_valid) begin
      cnt_d = '0;
      if (i_data == 8'hE0) begin
        state_d = S_EXT;
      end else if (i_data == 8'hF0) begin
        state_d = evt_ext_c ? S_EXT_BRK : S_BRK;
      end else begin
        evt_fire_c = 1'b1;
        state_d    = S_BASE;
      end
    end else if (state_q == S_BASE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_BASE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Held-key and pause next state; Space repeats while held do not toggle
  always_comb begin
    w_d     = w_q;
    s_d     = s_q;
    up_d    = up_q;
    dn_d    = dn_q;
    sp_d    = sp_q;
    pause_d = o_pause;
    if (evt_fire_c) begin
      if (!evt_ext_c) begin
        case (i_data)
          8'h1D:   w_d = !evt_brk_c;
          8'h1B:   s_d = !evt_brk_c;
          8'h29: begin
            sp_d = !evt_brk_c;
            if (!evt_brk_c && !sp_q) pause_d = !o_pause;
          end
          default: ;
        endcase
      end else begin
        case (i_data)
          8'h75:   up_d = !evt_brk_c;
          8'h72:   dn_d = !evt_brk_c;
          default: ;
        endcase
      end
    end
  end

  // Held registers and registered paddle outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      {w_q, s_q, up_q, dn_q, sp_q} <= '0;
      {o_p1_up, o_p1_down, o_p2_up, o_p2_down, o_pause} <= '0;
    end else begin
      {w_q, s_q, up_q, dn_q, sp_q} <= {w_d, s_d, up_d, dn_d, sp_d};
      o_p1_up   <= w_d & ~s_d;
      o_p1_down <= s_d & ~w_d;
      o_p2_up   <= up_d & ~dn_d;
      o_p2_down <= dn_d & ~up_d;
      o_pause   <= pause_d;
    end
  end

`ifdef PS2_KEY_EVENT_FIFO_EN
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENT_W = 10;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             pop_c, full_c, push_c, drop_c;

  assign pop_c   = o_evt_valid & i_evt_ready;
  assign full_c  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_c  = evt_fire_c & (~full_c | pop_c);
  assign drop_c  = evt_fire_c & full_c & ~pop_c;
  assign count_d = count_q + (PTR_W+1)'(push_c) - (PTR_W+1)'(pop_c);

  // Event FIFO; a push into a full FIFO that is popping in the same cycle is accepted
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
      o_evt_valid    <= 1'b0;
      o_evt_overflow <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_q] <= {i_data, evt_ext_c, evt_brk_c};
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_c) rd_q <= rd_q + PTR_W'(1);
      count_q     <= count_d;
      o_evt_valid <= (count_d != '0);
      if (drop_c) o_evt_overflow <= 1'b1;
    end
  end

  assign {o_evt_code, o_evt_ext, o_evt_brk} = mem_q[rd_q];
`else
  logic unused_evt_ready;
  assign unused_evt_ready = i_evt_ready;
  assign o_evt_overflow   = 1'b0;

  // Pulse valid once per event; fields hold until the next event
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_evt_valid <= 1'b0;
      o_evt_code  <= '0;
      o_evt_ext   <= 1'b0;
      o_evt_brk   <= 1'b0;
    end else begin
      o_evt_valid <= evt_fire_c;
      if (evt_fire_c) begin
        o_evt_code <= i_data;
        o_evt_ext  <= evt_ext_c;
        o_evt_brk  <= evt_brk_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench for ps2_key_controller: directed sequences plus random
// byte streams, all checked against a behavioural model. Expected events go
// through a scoreboard queue that a separate monitor drains.
module tb_ps2_key_controller;

  localparam int unsigned TO    = 16;
  localparam int unsigned DEPTH = 4;
`ifdef PS2_KEY_EVENT_FIFO_EN
  localparam bit FIFO_MODE = 1'b1;
`else
  localparam bit FIFO_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       evt_ready = 1'b1;
  logic       p1u, p1d, p2u, p2d, pause;
  logic       evt_valid, evt_ext, evt_brk, evt_ovf;
  logic [7:0] evt_code;

  ps2_key_controller #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_data_valid(valid),
    .o_p1_up(p1u), .o_p1_down(p1d), .o_p2_up(p2u), .o_p2_down(p2d),
    .o_pause(pause), .o_evt_valid(evt_valid), .o_evt_code(evt_code),
    .o_evt_ext(evt_ext), .o_evt_brk(evt_brk), .i_evt_ready(evt_ready),
    .o_evt_overflow(evt_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Behavioural model state
  bit m_ext, m_brk;
  int gap;
  bit h_w, h_s, h_up, h_dn, h_sp, m_pause, m_ovf;
  bit hold_mode;
  int held_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every event the DUT hands over
  always @(negedge clk) begin
    if (rst_n && evt_valid && (!FIFO_MODE || evt_ready)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL evt_unexpected: got %0h expected none", {evt_code, evt_ext, evt_brk});
      end else begin
        chk("evt", 32'({evt_code, evt_ext, evt_brk}), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    {m_ext, m_brk, h_w, h_s, h_up, h_dn, h_sp, m_pause, m_ovf} = '0;
    gap = 0;
    held_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".p1_up"},   32'(p1u),   32'(h_w && !h_s));
    chk({tag, ".p1_down"}, 32'(p1d),   32'(h_s && !h_w));
    chk({tag, ".p2_up"},   32'(p2u),   32'(h_up && !h_dn));
    chk({tag, ".p2_down"}, 32'(p2d),   32'(h_dn && !h_up));
    chk({tag, ".pause"},   32'(pause), 32'(m_pause));
    chk({tag, ".ovf"},     32'(evt_ovf), 32'(m_ovf));
  endtask

  // Called at a negedge; drives one byte sampled on the next posedge
  task automatic send_byte(input logic [7:0] b, input string tag);
    // A prefix survives as long as the byte lands within TO cycles of it
    if ((m_ext || m_brk) && (gap + 1 > int'(TO))) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_brk = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!hold_mode) exp_q.push_back({b, m_ext, m_brk});
      else if (held_cnt < int'(DEPTH)) begin
        exp_q.push_back({b, m_ext, m_brk});
        held_cnt++;
      end else m_ovf = 1'b1;
      if (!m_ext) begin
        if (b == 8'h1D) h_w = !m_brk;
        if (b == 8'h1B) h_s = !m_brk;
        if (b == 8'h29) begin
          if (!m_brk && !h_sp) m_pause = !m_pause;
          h_sp = !m_brk;
        end
      end else begin
        if (b == 8'h75) h_up = !m_brk;
        if (b == 8'h72) h_dn = !m_brk;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    gap = 0;
    data = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gap++;
    end
  endtask

  task automatic do_reset();
    chk("pre_reset_drain", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b0;
    data = 8'h1D;
    valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    model_reset();
    check_outputs("reset");
    chk("reset.evt_valid", 32'(evt_valid), 32'd0);
  endtask

  initial begin
    model_reset();
    hold_mode = 1'b0;
    @(negedge clk);
    do_reset();

    // W make then break
    send_byte(8'h1D, "w_make");
    chk("w_make.p1_up_const", 32'(p1u), 32'd1);
    send_byte(8'hF0, "w_f0");
    send_byte(8'h1D, "w_brk");
    chk("w_brk.p1_up_const", 32'(p1u), 32'd0);
    idle(2);

    // Up and Down together cancel, then releasing Up leaves Down
    send_byte(8'hE0, "up_e0");  send_byte(8'h75, "up_make");
    send_byte(8'hE0, "dn_e0");  send_byte(8'h72, "dn_make");
    chk("both.p2_up", 32'(p2u), 32'd0);
    chk("both.p2_down", 32'(p2d), 32'd0);
    send_byte(8'hE0, "upb_e0"); send_byte(8'hF0, "upb_f0"); send_byte(8'h75, "upb_brk");
    chk("upb.p2_down_const", 32'(p2d), 32'd1);

    // Space typematic repeats toggle pause only once per press
    send_byte(8'h29, "sp1");
    chk("sp1.pause_const", 32'(pause), 32'd1);
    send_byte(8'h29, "sp2");
    send_byte(8'h29, "sp3");
    send_byte(8'hF0, "spb_f0"); send_byte(8'h29, "spb");
    chk("spb.pause_const", 32'(pause), 32'd1);
    send_byte(8'h29, "sp4");
    chk("sp4.pause_const", 32'(pause), 32'd0);

    // Timeout discards F0; on the timeout cycle F0 still applies
    send_byte(8'hF0, "to_f0"); idle(TO); send_byte(8'h1B, "to_late");
    chk("to_late.p1_down_const", 32'(p1d), 32'd1);
    send_byte(8'hF0, "to2_f0"); idle(TO - 1); send_byte(8'h1B, "to_edge");
    chk("to_edge.p1_down_const", 32'(p1d), 32'd0);
    idle(3);

    // Reset after E0 discards the prefix
    send_byte(8'hE0, "mid_e0");
    do_reset();
    send_byte(8'h75, "mid_75");
    chk("mid.p2_up_const", 32'(p2u), 32'd0);
    idle(2);

    // Randomized byte stream
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0: b = 8'h1D;
        1: b = 8'h1B;
        2: b = 8'h75;
        3: b = 8'h72;
        4: b = 8'h29;
        5, 6: b = 8'hE0;
        7, 8: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      send_byte(b, "rnd");
      case ($urandom_range(0, 7))
        0: idle($urandom_range(0, TO + 2));
        1: idle(TO - 1);
        2: idle(TO);
        default: ;
      endcase
    end
    idle(2);

`ifdef PS2_KEY_EVENT_FIFO_EN
    // FIFO fill beyond capacity with the consumer stalled
    do_reset();
    @(posedge clk); #1 evt_ready = 1'b0;
    @(negedge clk);
    hold_mode = 1'b1;
    for (int i = 0; i < 6; i++) send_byte(8'h11 + 8'(i), "fill");
    chk("fill.evt_valid", 32'(evt_valid), 32'd1);
    chk("fill.ovf_const", 32'(evt_ovf), 32'd1);
    chk("fill.queued", 32'(exp_q.size()), 32'(DEPTH));
    @(posedge clk); #1 evt_ready = 1'b1;
    hold_mode = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain.evt_valid", 32'(evt_valid), 32'd0);
    chk("drain.ovf_sticky", 32'(evt_ovf), 32'd1);
`endif

    idle(2);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
